// File: rtl/uart_receiver_if.sv
// Read-side bundle of the UART receiver: received byte, frame status flags and the consumer acknowledge.
interface uart_receiver_if;
  logic [7:0] data_o;
  logic       read_ready_o;
  logic       parity_error_o;
  logic       framing_error_o;
  logic       overrun_o;
  logic       ack_i;

  modport master (
    output data_o,
    output read_ready_o,
    output parity_error_o,
    output framing_error_o,
    output overrun_o,
    input  ack_i
  );

  modport slave (
    input  data_o,
    input  read_ready_o,
    input  parity_error_o,
    input  framing_error_o,
    input  overrun_o,
    output ack_i
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receive engine: 8 data bits, optional parity, 1 or 2 stop bits, delivered on a ready/ack read side.
// Optional feature UART_RX_MAJORITY_VOTE_EN: each bit is the majority of three samples around mid-bit.
module uart_receiver #(
  parameter int unsigned CLOCK_DIVIDER_WIDTH = 16
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic                           two_stop_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic                           serial_i,
  output logic                           busy_o,
  uart_receiver_if.master                rd
);

  localparam int unsigned CDW       = CLOCK_DIVIDER_WIDTH;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BREAK_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  line_prev_q;
  logic [CDW-1:0]        cnt_q, cnt_d;
  logic [CDW-1:0]        div_q, div_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  two_stop_q, two_stop_d;
  logic                  par_en_q, par_en_d;
  logic                  par_even_q, par_even_d;
  logic                  par_err_q, par_err_d;
  logic                  frm_err_q, frm_err_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  busy_q, busy_d;

  logic                  rx;
  logic                  bit_val;
  logic                  at_sample;
  logic                  complete;
  logic                  frame_ferr;
  logic                  parity_exp;
  logic [CDW-1:0]        sample_tgt;

  assign rx = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q, vote_d;

  // Decision moves to mid+1 so mid-1 and mid can be captured beforehand.
  always_comb begin
    sample_tgt = (state_q == S_START) ? (div_q >> 1) + CDW'(1) : div_q - CDW'(1);
    at_sample  = (cnt_q == sample_tgt);
    vote_d     = vote_q;
    if (cnt_q == sample_tgt - CDW'(2)) vote_d[0] = rx;
    if (cnt_q == sample_tgt - CDW'(1)) vote_d[1] = rx;
    bit_val    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx) | (vote_q[1] & rx);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) vote_q <= 2'b11;
    else         vote_q <= vote_d;
  end
`else
  // Single sample at mid-bit.
  always_comb begin
    sample_tgt = (state_q == S_START) ? (div_q >> 1) : div_q - CDW'(1);
    at_sample  = (cnt_q == sample_tgt);
    bit_val    = rx;
  end
`endif

  assign parity_exp = par_even_q ? (^shift_q) : ~(^shift_q);

  // Next-state, datapath and output update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    div_d      = div_q;
    two_stop_d = two_stop_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    data_d     = data_q;
    ready_d    = ready_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    complete   = 1'b0;
    frame_ferr = frm_err_q;

    if (rd.ack_i && ready_q) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end

    if (state_q != S_IDLE && state_q != S_BREAK_WAIT) cnt_d = cnt_q + CDW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (line_prev_q && !rx) begin
          state_d    = S_START;
          cnt_d      = '0;
          bit_d      = '0;
          div_d      = clock_divider_i;
          two_stop_d = two_stop_bits_i;
          par_en_d   = parity_bit_i;
          par_even_d = parity_even_i;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end
      end
      S_START: begin
        if (at_sample) begin
          cnt_d   = '0;
          state_d = bit_val ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (at_sample) begin
          cnt_d   = '0;
          shift_d = {bit_val, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + BIT_CNT_W'(1);
          if (bit_q == BIT_CNT_W'(DATA_W - 1)) state_d = par_en_q ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (at_sample) begin
          cnt_d     = '0;
          par_err_d = (bit_val != parity_exp);
          state_d   = S_STOP1;
        end
      end
      S_STOP1: begin
        if (at_sample) begin
          cnt_d      = '0;
          frame_ferr = frm_err_q | ~bit_val;
          frm_err_d  = frame_ferr;
          if (two_stop_q) state_d = S_STOP2;
          else            complete = 1'b1;
        end
      end
      S_STOP2: begin
        if (at_sample) begin
          cnt_d      = '0;
          frame_ferr = frm_err_q | ~bit_val;
          frm_err_d  = frame_ferr;
          complete   = 1'b1;
        end
      end
      S_BREAK_WAIT: begin
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new frame overrides a same-cycle ack; overrun only if the old byte was never taken.
    if (complete) begin
      data_d  = shift_q;
      perr_d  = par_err_q;
      ferr_d  = frame_ferr;
      ready_d = 1'b1;
      ovr_d   = ready_q & ~rd.ack_i;
      state_d = (frame_ferr && shift_q == '0) ? S_BREAK_WAIT : S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      two_stop_q  <= 1'b0;
      par_en_q    <= 1'b0;
      par_even_q  <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], serial_i};
      line_prev_q <= rx;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      two_stop_q  <= two_stop_d;
      par_en_q    <= par_en_d;
      par_even_q  <= par_even_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
    end
  end

  assign rd.data_o          = data_q;
  assign rd.read_ready_o    = ready_q;
  assign rd.parity_error_o  = perr_q;
  assign rd.framing_error_o = ferr_q;
  assign rd.overrun_o       = ovr_q;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are queued as they are driven and checked when delivered.
module tb_uart_receiver;

  localparam int unsigned CDW = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int unsigned VADJ = 1;
`else
  localparam int unsigned VADJ = 0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    logic        ovr;
    int unsigned start;
    int unsigned lat;
  } exp_t;

  logic           clock_i;
  logic           reset_i;
  logic [CDW-1:0] clock_divider;
  logic           two_stop;
  logic           par_bit;
  logic           par_even;
  logic           serial;
  logic           busy;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        rdy_prev = 1'b0;
  logic        ovr_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;

  uart_receiver_if rd_if();

  uart_receiver #(.CLOCK_DIVIDER_WIDTH(CDW)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .clock_divider_i (clock_divider),
    .two_stop_bits_i (two_stop),
    .parity_bit_i    (par_bit),
    .parity_even_i   (par_even),
    .serial_i        (serial),
    .busy_o          (busy),
    .rd              (rd_if)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned lat_of(input int unsigned d, input bit p, input bit t);
    return 3 + d / 2 + (9 + int'(p) + int'(t)) * d + VADJ;
  endfunction

  // Delivery monitor: a rising ready, a changed byte or a rising overrun marks a new frame.
  always @(negedge clock_i) begin
    if (!reset_i && rd_if.read_ready_o &&
        (!rdy_prev || rd_if.data_o != data_prev || (rd_if.overrun_o && !ovr_prev))) begin
      if (sb_q.size() == 0) begin
        check("unexpected_frame", 32'(rd_if.data_o), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check("data",    32'(rd_if.data_o),          32'(mon_e.data));
        check("perr",    32'(rd_if.parity_error_o),  32'(mon_e.perr));
        check("ferr",    32'(rd_if.framing_error_o), 32'(mon_e.ferr));
        check("overrun", 32'(rd_if.overrun_o),       32'(mon_e.ovr));
        check("latency", 32'(cyc - mon_e.start),     32'(mon_e.lat));
      end
    end
    rdy_prev  = rd_if.read_ready_o;
    ovr_prev  = rd_if.overrun_o;
    data_prev = rd_if.data_o;
  end

  task automatic drive_bit(input logic b, input int unsigned d);
    serial = b;
    repeat (d) @(negedge clock_i);
  endtask

  // Called at a negedge with the receiver idle; the start bit goes out immediately.
  task automatic send_frame(input logic [7:0] d, input int unsigned dv, input bit pen, input bit peven,
                            input bit bad_par, input bit two, input bit exp_ovr);
    exp_t e;
    logic p;
    clock_divider = CDW'(dv);
    par_bit       = pen;
    par_even      = peven;
    two_stop      = two;
    e.data  = d;
    e.perr  = bad_par;
    e.ferr  = 1'b0;
    e.ovr   = exp_ovr;
    e.start = cyc + 1;
    e.lat   = lat_of(dv, pen, two);
    sb_q.push_back(e);
    drive_bit(1'b0, dv);
    for (int i = 0; i < 8; i++) drive_bit(d[i], dv);
    if (pen) begin
      p = peven ? ^d : ~^d;
      drive_bit(p ^ bad_par, dv);
    end
    drive_bit(1'b1, dv);
    if (two) drive_bit(1'b1, dv);
  endtask

  task automatic wait_drain(input int unsigned max_cyc);
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(negedge clock_i);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic ack_pulse();
    rd_if.ack_i = 1'b1;
    @(negedge clock_i);
    rd_if.ack_i = 1'b0;
    @(negedge clock_i);
    check("ack_ready", 32'(rd_if.read_ready_o), 32'd0);
    check("ack_ovr",   32'(rd_if.overrun_o),    32'd0);
  endtask

  initial begin
    int unsigned e0;
    int unsigned l87;
    serial        = 1'b1;
    rd_if.ack_i   = 1'b0;
    reset_i       = 1'b1;
    clock_divider = CDW'(87);
    two_stop      = 1'b0;
    par_bit       = 1'b0;
    par_even      = 1'b0;
    l87           = lat_of(87, 1'b0, 1'b0);
    repeat (4) @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);

    check("rst_data",  32'(rd_if.data_o),          32'd0);
    check("rst_ready", 32'(rd_if.read_ready_o),    32'd0);
    check("rst_perr",  32'(rd_if.parity_error_o),  32'd0);
    check("rst_ferr",  32'(rd_if.framing_error_o), 32'd0);
    check("rst_ovr",   32'(rd_if.overrun_o),       32'd0);
    check("rst_busy",  32'(busy),                  32'd0);

    // Plain 8N1, parity variants, two stop bits, minimum divider
    send_frame(8'hA5, 87, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); wait_drain(2000); ack_pulse();
    send_frame(8'h03, 87, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); wait_drain(2000); ack_pulse();
    send_frame(8'h03, 87, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); wait_drain(2000); ack_pulse();
    send_frame(8'hC4, 87, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); wait_drain(2000); ack_pulse();
    send_frame(8'h96, 4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0); wait_drain(200);  ack_pulse();

    // Short low glitch: false start, back to idle at mid-start + 3
    clock_divider = CDW'(87);
    par_bit       = 1'b0;
    two_stop      = 1'b0;
    e0     = cyc + 1;
    serial = 1'b0;
    repeat (20) @(negedge clock_i);
    serial = 1'b1;
    while (cyc < e0 + 2 + 43 + VADJ) @(negedge clock_i);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    @(negedge clock_i);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    repeat (200) @(negedge clock_i);
    check("glitch_ready", 32'(rd_if.read_ready_o), 32'd0);

    // Break: line low for 2000 cycles yields one 0x00 frame with framing error
    e0 = cyc + 1;
    sb_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, ovr: 1'b0, start: e0, lat: l87});
    serial = 1'b0;
    wait_drain(1500);
    ack_pulse();
    while (cyc < e0 + 1999) @(negedge clock_i);
    check("break_wait_busy", 32'(busy), 32'd1);
    serial = 1'b1;
    repeat (2 * 87) @(negedge clock_i);
    check("break_idle_busy", 32'(busy), 32'd0);
    send_frame(8'h5A, 87, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); wait_drain(2000); ack_pulse();

    // Overrun: two frames without ack
    send_frame(8'h11, 87, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 87, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain(2000);
    check("ovr_ready", 32'(rd_if.read_ready_o), 32'd1);
    check("ovr_flag",  32'(rd_if.overrun_o),    32'd1);
    check("ovr_data",  32'(rd_if.data_o),       32'h22);
    ack_pulse();

    // Ack in the completion cycle: new frame wins, no overrun
    send_frame(8'h77, 87, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain(2000);
    e0 = cyc + 1;
    fork
      send_frame(8'h88, 87, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
        while (cyc < e0 + l87 - 1) @(negedge clock_i);
        rd_if.ack_i = 1'b1;
        @(negedge clock_i);
        rd_if.ack_i = 1'b0;
      end
    join
    wait_drain(2000);
    check("same_ready", 32'(rd_if.read_ready_o), 32'd1);
    check("same_ovr",   32'(rd_if.overrun_o),    32'd0);
    check("same_data",  32'(rd_if.data_o),       32'h88);

    // Reset in the middle of a 0xFF frame, with a byte still pending
    serial = 1'b0;
    repeat (87) @(negedge clock_i);
    serial = 1'b1;
    repeat (3 * 87) @(negedge clock_i);
    check("mid_busy", 32'(busy), 32'd1);
    reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    check("mr_data",  32'(rd_if.data_o),          32'd0);
    check("mr_ready", 32'(rd_if.read_ready_o),    32'd0);
    check("mr_ovr",   32'(rd_if.overrun_o),       32'd0);
    check("mr_ferr",  32'(rd_if.framing_error_o), 32'd0);
    check("mr_perr",  32'(rd_if.parity_error_o),  32'd0);
    check("mr_busy",  32'(busy),                  32'd0);
    repeat (8 * 87) @(negedge clock_i);
    send_frame(8'h3C, 87, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); wait_drain(2000); ack_pulse();

    repeat (20) @(negedge clock_i);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
